fhe_cmd_frontend: RTL and testbench
===================================

FHE_CMD_FRONTEND -- requirements
Module: fhe_cmd_frontend

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h30000000: base of the accelerator Wishbone window; the opcode/status register sits at this address.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: scratch-memory word-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: command-queue entries, power of two.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with these ports:
- wb_clk_i  in  1: clock.
- wb_rst_i  in  1: asynchronous active-high reset.
REQ-005 SHALL have the following Wishbone slave ports:
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each: strobe, cycle, write enable.
- wbs_sel_i  in  4: byte selects.
- wbs_dat_i  in  32: write data.
- wbs_adr_i  in  32: byte address.
- wbs_ack_o  out  1: acknowledge.
- wbs_dat_o  out  32: read data.
REQ-006 SHALL have the following memory ports:
- mem_req_o  out  1: access request.
- mem_we_o  out  1: write enable.
- mem_be_o  out  4: byte enables.
- mem_addr_o  out  ADDR_WIDTH: word address.
- mem_wdata_o  out  32: write data.
- mem_gnt_i  in  1: grant.
- mem_rdata_i  in  32: read data, valid the cycle after grant.
REQ-007 SHALL have the following core command ports:
- cmd_valid_o  out  1: command valid.
- cmd_ready_i  in  1: core accepts.
- cmd_op_o  out  2: opcode.
- cmd_src_a_o  out  ADDR_WIDTH: source A address.
- cmd_src_b_o  out  ADDR_WIDTH: source B address.
- cmd_dst_o  out  ADDR_WIDTH: destination address.
- core_busy_i  in  1: core executing.

Function
REQ-008 SHALL decode a cycle as active when wbs_stb_i & wbs_cyc_i; offset = wbs_adr_i - BASE_ADDR.
REQ-009 SHALL treat offset 0 as the opcode/status register.
REQ-010 SHALL treat offsets 4 .. 4*(2^ADDR_WIDTH)-1 as memory, with mem_addr_o = offset[ADDR_WIDTH+1:2].
REQ-011 SHALL treat any other address as unmapped: ack with wbs_dat_o=0 and no side effects.
REQ-012 SHALL implement the FSM IDLE -> {REG, MEM_REQ} -> (MEM_RD) -> ACK -> RELEASE -> IDLE.
REQ-013 SHALL leave RELEASE only when stb or cyc is low, so a strobe held across several cycles executes exactly once.
REQ-014 SHALL pulse wbs_ack_o high for exactly one cycle, in state ACK.
REQ-015 SHALL ack a register access on the 2nd cycle after strobe is sampled in IDLE.
REQ-016 SHALL hold mem_req_o high in MEM_REQ until mem_gnt_i; a write acks the cycle after grant, a read captures mem_rdata_i the cycle after grant and acks the cycle after that.
REQ-017 SHALL, on an opcode write with wbs_dat_i[31]=1, push {[1:0] op, [10:2] src_a, [19:11] src_b, [28:20] dst} into the FIFO.
REQ-018 SHALL ack an opcode write with bit31=0 and otherwise ignore it.
REQ-019 SHALL, on a push while the FIFO is full, drop the command and set sticky overflow; the write is still acked.
REQ-020 SHALL return status on an opcode read: [3:0] count, [4] empty, [5] full, [6] core_busy_i, [7] overflow, other bits 0.
REQ-021 SHALL clear overflow when that status read is acked.
REQ-022 SHALL drive cmd_valid_o = FIFO not empty, with the cmd_* fields taken from the FIFO head, and pop when cmd_valid_o & cmd_ready_i.
REQ-023 SHALL leave the count unchanged on a simultaneous push and pop, including when full; the push is accepted.
REQ-024 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-025 SHALL keep cmd_* fields stable while cmd_valid_o=1 and cmd_ready_i=0.

Reset
REQ-026 SHALL, while wb_rst_i=1, immediately force to 0: wbs_ack_o, wbs_dat_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, cmd_valid_o, FIFO count, FIFO pointers, overflow; FSM=IDLE.
REQ-027 SHALL abandon an in-flight memory access or command on reset and not replay it afterwards.

Configuration
REQ-028 SHALL, with macro FHE_CMD_FIFO_EN defined, implement the FIFO_DEPTH-entry queue.
REQ-029 SHALL, without FHE_CMD_FIFO_EN, ignore FIFO_DEPTH and use a single holding register (depth 1), with full = valid; status and overflow semantics are unchanged.

Verification
REQ-030 SHALL pass: write 32'd20 to 0x30000194, strobe held 2 cycles -> one mem write, addr 101, data 20, single ack.
REQ-031 SHALL pass: read 0x30000194 after that write, mem_gnt_i delayed 3 cycles -> wbs_dat_o=20 with ack 2 cycles after grant.
REQ-032 SHALL pass: write 0x83232002 to 0x30000000, cmd_ready_i=1 -> cmd_valid_o pulse with op=2, src_a=0, src_b=100, dst=50.
REQ-033 SHALL pass (FIFO enabled): cmd_ready_i=0, 5 opcode writes -> status read = 0x000000A4 (count 4, full, overflow); a second status read shows overflow=0.
REQ-034 SHALL pass: simultaneous push and pop while full -> count stays 4, newest command retained.
REQ-035 SHALL pass: assert wb_rst_i during MEM_REQ -> mem_req_o and cmd_valid_o drop at once; after release, status read = 0x00000010.

Source files
------------

// File: rtl/fhe_cmd_frontend_if.sv
// Wishbone slave bus of the FHE accelerator command frontend.
// The frontend takes the slave modport and the bus master takes the master modport.
interface fhe_cmd_frontend_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fhe_cmd_frontend.sv
// Wishbone frontend for the FHE core: scratch-memory bridge plus opcode/status register feeding a command queue.
// Define FHE_CMD_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module fhe_cmd_frontend #(
  parameter logic [31:0] BASE_ADDR  = 32'h30000000,
  parameter int          ADDR_WIDTH = 9,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  fhe_cmd_frontend_if.slave     wbs,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [1:0]            cmd_op_o,
  output logic [ADDR_WIDTH-1:0] cmd_src_a_o,
  output logic [ADDR_WIDTH-1:0] cmd_src_b_o,
  output logic [ADDR_WIDTH-1:0] cmd_dst_o,
  input  logic                  core_busy_i
);

`ifdef FHE_CMD_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  // FIFO_DEPTH has no effect in the holding-register build.
  localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, REG, MEM_REQ, MEM_RD, ACK, RELEASE} state_t;

  state_t      state;
  logic        acc_reg;
  logic        acc_we;
  logic [29:0] acc_cmd;

  logic [31:0] offset;
  logic        reg_hit;
  logic        mem_hit;
  logic        active;

  logic [28:0] fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          status_ack;
  logic [31:0]   status;
  logic [28:0]   head;

  assign active  = wbs.wbs_stb_i && wbs.wbs_cyc_i;
  assign offset  = wbs.wbs_adr_i - BASE_ADDR;
  assign reg_hit = (offset == '0);
  assign mem_hit = (offset[31:ADDR_WIDTH+2] == '0) && (offset[ADDR_WIDTH+1:2] != '0);

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop        = cmd_valid_o && cmd_ready_i;
  assign push_req   = (state == REG) && acc_reg && acc_we && acc_cmd[29];
  assign push_ok    = push_req && (!full || pop);
  assign status_ack = (state == ACK) && acc_reg && !acc_we;
  assign status     = {24'b0, overflow, core_busy_i, full, empty, 4'(count)};

  assign head        = fifo_q[rd_ptr];
  assign cmd_valid_o = !empty;
  assign cmd_op_o    = head[1:0];
  assign cmd_src_a_o = ADDR_WIDTH'(head[10:2]);
  assign cmd_src_b_o = ADDR_WIDTH'(head[19:11]);
  assign cmd_dst_o   = ADDR_WIDTH'(head[28:20]);

  // Bus FSM: one execution per strobe; RELEASE waits for the master to drop the cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      acc_reg       <= 1'b0;
      acc_we        <= 1'b0;
      acc_cmd       <= '0;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_be_o      <= '0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (active) begin
            acc_reg <= reg_hit;
            acc_we  <= wbs.wbs_we_i;
            acc_cmd <= {wbs.wbs_dat_i[31], wbs.wbs_dat_i[28:0]};
            if (mem_hit) begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= wbs.wbs_we_i;
              mem_be_o    <= wbs.wbs_sel_i;
              mem_addr_o  <= offset[ADDR_WIDTH+1:2];
              mem_wdata_o <= wbs.wbs_dat_i;
              state       <= MEM_REQ;
            end else begin
              state <= REG;
            end
          end
        end
        REG: begin
          wbs.wbs_dat_o <= (acc_reg && !acc_we) ? status : '0;
          wbs.wbs_ack_o <= 1'b1;
          state         <= ACK;
        end
        MEM_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (mem_we_o) begin
              wbs.wbs_ack_o <= 1'b1;
              state         <= ACK;
            end else begin
              state <= MEM_RD;
            end
          end
        end
        MEM_RD: begin
          wbs.wbs_dat_o <= mem_rdata_i;
          wbs.wbs_ack_o <= 1'b1;
          state         <= ACK;
        end
        ACK: begin
          wbs.wbs_ack_o <= 1'b0;
          wbs.wbs_dat_o <= '0;
          state         <= RELEASE;
        end
        RELEASE: begin
          if (!active) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A push into a full queue is still accepted when the head pops in the same cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)     rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (status_ack)      overflow <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) fifo_q[wr_ptr] <= acc_cmd[28:0];
  end

endmodule

// File: tb/tb_fhe_cmd_frontend.sv
// Directed self-checking bench for fhe_cmd_frontend (works with or without FHE_CMD_FIFO_EN).
module tb_fhe_cmd_frontend;
  localparam logic [31:0] BASE = 32'h30000000;
`ifdef FHE_CMD_FIFO_EN
  localparam int EXP_DEPTH = 4;
`else
  localparam int EXP_DEPTH = 1;
`endif

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i;
  logic [3:0]  mem_be_o;
  logic [8:0]  mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        cmd_valid_o, cmd_ready_i, core_busy_i;
  logic [1:0]  cmd_op_o;
  logic [8:0]  cmd_src_a_o, cmd_src_b_o, cmd_dst_o;

  fhe_cmd_frontend_if wb_bus ();

  fhe_cmd_frontend dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs         (wb_bus.slave),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rdata_i (mem_rdata_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_op_o    (cmd_op_o),
    .cmd_src_a_o (cmd_src_a_o),
    .cmd_src_b_o (cmd_src_b_o),
    .cmd_dst_o   (cmd_dst_o),
    .core_busy_i (core_busy_i)
  );

  int checks = 0;
  int errors = 0;
  int gnt_delay = 0;
  int wait_cnt = 0;
  int wr_count = 0;
  int gnt_count = 0;
  int ack_count = 0;
  int pop_count = 0;
  logic [8:0]  last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;
  logic [1:0]  pop_op;
  logic [8:0]  pop_src_a, pop_src_b, pop_dst;
  logic [31:0] mem_model [512];

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) begin
    if (wb_bus.wbs_ack_o) ack_count++;
    if (cmd_valid_o && cmd_ready_i) begin
      pop_count++;
      pop_op    = cmd_op_o;
      pop_src_a = cmd_src_a_o;
      pop_src_b = cmd_src_b_o;
      pop_dst   = cmd_dst_o;
    end
  end

  // Scratch memory responder: grants after gnt_delay waiting cycles, read data held from grant onwards.
  initial begin
    mem_gnt_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge wb_clk_i);
      if (mem_req_o && !mem_gnt_i) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          gnt_count++;
          if (mem_we_o) begin
            mem_model[mem_addr_o] = mem_wdata_o;
            wr_count++;
            last_addr  = mem_addr_o;
            last_wdata = mem_wdata_o;
            last_be    = mem_be_o;
          end else begin
            mem_rdata_i = mem_model[mem_addr_o];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_gnt_i = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] make_cmd(input int k);
    return 32'h80000000 | 32'(k << 20) | 32'((k + 10) << 11) | 32'(k << 2) | 32'(k & 3);
  endfunction

  // One Wishbone access; lat counts cycles from the IDLE sampling edge to the ack cycle.
  task automatic apply_stimulus(input string tag, input logic [31:0] adr, input logic we,
                                input logic [31:0] wdat, input logic pop_in_reg,
                                output logic [31:0] rdat, output int lat);
    bit done;
    done = 0;
    rdat = '0;
    lat  = 0;
    @(negedge wb_clk_i);
    wb_bus.wbs_adr_i = adr;
    wb_bus.wbs_we_i  = we;
    wb_bus.wbs_dat_i = wdat;
    wb_bus.wbs_sel_i = 4'hF;
    wb_bus.wbs_stb_i = 1'b1;
    wb_bus.wbs_cyc_i = 1'b1;
    @(posedge wb_clk_i);
    if (pop_in_reg) begin
      #1 cmd_ready_i = 1'b1;
    end
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge wb_clk_i);
      lat++;
      if (pop_in_reg && lat == 2) cmd_ready_i = 1'b0;
      if (wb_bus.wbs_ack_o) begin
        rdat = wb_bus.wbs_dat_o;
        done = 1;
      end
    end
    if (pop_in_reg) cmd_ready_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_timeout observed no ack expected ack", tag);
    end
    @(negedge wb_clk_i);
    wb_bus.wbs_stb_i = 1'b0;
    wb_bus.wbs_cyc_i = 1'b0;
    wb_bus.wbs_we_i  = 1'b0;
  endtask

  task automatic status_read(input string tag, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    apply_stimulus(tag, BASE, 1'b0, 32'h0, 1'b0, rd, lat);
    check_output(tag, rd, exp);
    check_output({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, ack0, wr0, gnt0, pop0;
    int exp_dst[$];

    wb_rst_i = 1'b1;
    wb_bus.wbs_stb_i = 1'b0;
    wb_bus.wbs_cyc_i = 1'b0;
    wb_bus.wbs_we_i  = 1'b0;
    wb_bus.wbs_sel_i = 4'h0;
    wb_bus.wbs_dat_i = '0;
    wb_bus.wbs_adr_i = '0;
    cmd_ready_i = 1'b0;
    core_busy_i = 1'b0;

    repeat (3) @(negedge wb_clk_i);
    check_output("rst_ack", 32'(wb_bus.wbs_ack_o), 32'd0);
    check_output("rst_req", 32'(mem_req_o), 32'd0);
    check_output("rst_valid", 32'(cmd_valid_o), 32'd0);
    check_output("rst_dat", wb_bus.wbs_dat_o, 32'd0);
    wb_rst_i = 1'b0;

    status_read("status_after_reset", 32'h00000010);

    // Memory write with strobe held past the ack.
    ack0 = ack_count; wr0 = wr_count;
    apply_stimulus("mem_wr", 32'h30000194, 1'b1, 32'd20, 1'b0, rd, lat);
    repeat (2) @(negedge wb_clk_i);
    check_output("mem_wr_lat", 32'(lat), 32'd2);
    check_output("mem_wr_acks", 32'(ack_count - ack0), 32'd1);
    check_output("mem_wr_count", 32'(wr_count - wr0), 32'd1);
    check_output("mem_wr_addr", 32'(last_addr), 32'd101);
    check_output("mem_wr_data", last_wdata, 32'd20);
    check_output("mem_wr_be", 32'(last_be), 32'hF);

    // Read back with a 3-cycle grant delay.
    gnt_delay = 3;
    ack0 = ack_count;
    apply_stimulus("mem_rd", 32'h30000194, 1'b0, 32'h0, 1'b0, rd, lat);
    check_output("mem_rd_data", rd, 32'd20);
    check_output("mem_rd_lat", 32'(lat), 32'd6);
    check_output("mem_rd_acks", 32'(ack_count - ack0), 32'd1);
    gnt_delay = 0;

    // Top word of the memory window.
    apply_stimulus("mem_top_wr", 32'h300007FC, 1'b1, 32'hDEADBEEF, 1'b0, rd, lat);
    check_output("mem_top_addr", 32'(last_addr), 32'd511);
    apply_stimulus("mem_top_rd", 32'h300007FC, 1'b0, 32'h0, 1'b0, rd, lat);
    check_output("mem_top_data", rd, 32'hDEADBEEF);

    // Unmapped accesses: just above the window and just below the base.
    gnt0 = gnt_count;
    apply_stimulus("unmapped_rd", 32'h30000800, 1'b0, 32'h0, 1'b0, rd, lat);
    check_output("unmapped_rd_data", rd, 32'h0);
    check_output("unmapped_rd_lat", 32'(lat), 32'd2);
    apply_stimulus("unmapped_wr", 32'h2FFFFFFC, 1'b1, 32'h80000001, 1'b0, rd, lat);
    check_output("unmapped_no_mem", 32'(gnt_count - gnt0), 32'd0);
    status_read("status_after_unmapped", 32'h00000010);

    // Single command issued to a ready core.
    cmd_ready_i = 1'b1;
    pop0 = pop_count;
    apply_stimulus("op_wr", BASE, 1'b1, 32'h83232002, 1'b0, rd, lat);
    repeat (2) @(negedge wb_clk_i);
    check_output("cmd_pops", 32'(pop_count - pop0), 32'd1);
    check_output("cmd_op", 32'(pop_op), 32'd2);
    check_output("cmd_src_a", 32'(pop_src_a), 32'd0);
    check_output("cmd_src_b", 32'(pop_src_b), 32'd100);
    check_output("cmd_dst", 32'(pop_dst), 32'd50);
    check_output("cmd_valid_drop", 32'(cmd_valid_o), 32'd0);
    cmd_ready_i = 1'b0;

    // Opcode write without the go bit is ignored.
    apply_stimulus("op_nogo", BASE, 1'b1, 32'h03232002, 1'b0, rd, lat);
    status_read("status_after_nogo", 32'h00000010);

    // Fill past capacity with the core stalled.
    for (int k = 1; k <= 5; k++) apply_stimulus("fill", BASE, 1'b1, make_cmd(k), 1'b0, rd, lat);
    check_output("fill_valid", 32'(cmd_valid_o), 32'd1);
    check_output("fill_head", 32'(cmd_dst_o), 32'd1);
    status_read("status_full_ovf", 32'h000000A0 | 32'(EXP_DEPTH));
    status_read("status_ovf_cleared", 32'h00000020 | 32'(EXP_DEPTH));

    // Push and pop in the same cycle while full.
    pop0 = pop_count;
    apply_stimulus("push_pop", BASE, 1'b1, make_cmd(6), 1'b1, rd, lat);
    check_output("push_pop_pops", 32'(pop_count - pop0), 32'd1);
    check_output("push_pop_popped", 32'(pop_dst), 32'd1);
    status_read("status_push_pop", 32'h00000020 | 32'(EXP_DEPTH));

`ifdef FHE_CMD_FIFO_EN
    exp_dst = '{2, 3, 4, 6};
`else
    exp_dst = '{6};
`endif
    @(negedge wb_clk_i);
    check_output("stable_dst_a", 32'(cmd_dst_o), 32'(exp_dst[0]));
    repeat (3) @(negedge wb_clk_i);
    check_output("stable_dst_b", 32'(cmd_dst_o), 32'(exp_dst[0]));
    check_output("stable_src_b", 32'(cmd_src_b_o), 32'(exp_dst[0] + 10));
    foreach (exp_dst[i]) begin
      if (i > 0) @(negedge wb_clk_i);
      check_output("drain_valid", 32'(cmd_valid_o), 32'd1);
      check_output("drain_dst", 32'(cmd_dst_o), 32'(exp_dst[i]));
      cmd_ready_i = 1'b1;
    end
    @(negedge wb_clk_i);
    check_output("drain_empty", 32'(cmd_valid_o), 32'd0);
    cmd_ready_i = 1'b0;

    // Reset while a memory request is stalled and a command is pending.
    apply_stimulus("pre_rst_cmd", BASE, 1'b1, make_cmd(7), 1'b0, rd, lat);
    check_output("pre_rst_valid", 32'(cmd_valid_o), 32'd1);
    gnt_delay = 1000;
    @(negedge wb_clk_i);
    wb_bus.wbs_adr_i = BASE + 32'h10;
    wb_bus.wbs_we_i  = 1'b1;
    wb_bus.wbs_dat_i = 32'h55;
    wb_bus.wbs_sel_i = 4'hF;
    wb_bus.wbs_stb_i = 1'b1;
    wb_bus.wbs_cyc_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_output("stall_req", 32'(mem_req_o), 32'd1);
    wr0 = wr_count;
    #1 wb_rst_i = 1'b1;
    #1;
    check_output("rst_mid_req", 32'(mem_req_o), 32'd0);
    check_output("rst_mid_valid", 32'(cmd_valid_o), 32'd0);
    wb_bus.wbs_stb_i = 1'b0;
    wb_bus.wbs_cyc_i = 1'b0;
    wb_bus.wbs_we_i  = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i  = 1'b0;
    gnt_delay = 0;
    repeat (3) @(negedge wb_clk_i);
    check_output("no_replay_req", 32'(mem_req_o), 32'd0);
    check_output("no_replay_wr", 32'(wr_count - wr0), 32'd0);
    status_read("status_after_mid_reset", 32'h00000010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
